// File: rtl/add_sub_seq.sv
// Chunk-serial adder/subtractor: processes CHUNK bits per cycle over N = WIDTH/CHUNK cycles,
// with a valid/ready handshake on both sides and a synchronous flush.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready=1
// BUSY  | summing chunk k of a and b' with the running carry
// DONE  | result and flags valid, held until out_ready or flush
module add_sub_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int N  = WIDTH / CHUNK;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q, res_nxt;
   logic             sub_q, carry_q;
   logic [KW-1:0]    k_q;
   logic [CHUNK:0]   sum;
   logic             accept, step, last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid && !flush) begin
               accept    = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (flush)              state_nxt = IDLE;
            else if (k_q == K_LAST) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (flush || out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign step = (state == BUSY) && !flush;
   assign last = step && (k_q == K_LAST);

   // b is stored already inverted for subtraction, so the datapath only ever adds.
   always_comb begin
      sum     = {1'b0, a_q[k_q*CHUNK +: CHUNK]} + {1'b0, b_q[k_q*CHUNK +: CHUNK]}
              + (CHUNK+1)'(carry_q);
      res_nxt = result;
      res_nxt[k_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         k_q     <= '0;
         result  <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
         zero    <= 1'b0;
         neg     <= 1'b0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= sub ? ~b : b;
         sub_q   <= sub;
         carry_q <= sub;
         k_q     <= '0;
      end else if (step) begin
         result  <= res_nxt;
         carry_q <= sum[CHUNK];
         k_q     <= k_q + KW'(1);
         if (last) begin
            cout <= sum[CHUNK] ^ sub_q;
            ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[CHUNK-1] != a_q[WIDTH-1]);
            zero <= (res_nxt == '0);
            neg  <= sum[CHUNK-1];
         end
      end
   end

endmodule

// File: doc/add_sub_seq.md
ADD_SUB_SEQ -- requirements
Module: add_sub_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK, and N = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, operands and mode valid.
REQ-006 The block SHALL have port in_ready, output, 1, block can accept an operation.
REQ-007 The block SHALL have ports a and b, input, WIDTH each, operands.
REQ-008 The block SHALL have port sub, input, 1; 0 selects a+b, 1 selects a-b.
REQ-009 The block SHALL have port flush, input, 1, synchronous abort of the operation in flight.
REQ-010 The block SHALL have port out_valid, output, 1, result fields valid.
REQ-011 The block SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 The block SHALL have port result, output, WIDTH, sum or difference modulo 2^WIDTH.
REQ-013 The block SHALL have port cout, output, 1: carry-out for add; borrow for sub (1 iff a < b unsigned).
REQ-014 The block SHALL have ports ovf, zero and neg, output, 1 each: signed overflow, result==0, and result[WIDTH-1].

Function
REQ-015 The block SHALL implement FSM states IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-016 On IDLE with in_valid=1, the block SHALL register a, b and sub, set the chunk index k=0, set the running carry to sub, and enter BUSY.
REQ-017 Subtraction SHALL be computed as a + ~b + 1, using bitwise inversion of b and carry-in 1.
REQ-018 In each BUSY cycle, the block SHALL add chunk k of a and (possibly inverted) b plus the running carry, write result bits [k*CHUNK +: CHUNK], update the running carry, and increment k.
REQ-019 After chunk N-1 the block SHALL enter DONE, so out_valid rises exactly N cycles after the accepting edge (4 for the defaults).
REQ-020 In DONE the block SHALL set: cout = final carry XOR sub; ovf = (a[MSB]==b'[MSB]) AND (result[MSB]!=a[MSB]), where b' is the possibly inverted b; zero and neg from the full result.
REQ-021 The block SHALL hold result and all flags stable while out_valid=1 and out_ready=0, with no limit on the stall length.
REQ-022 On DONE with out_ready=1 the block SHALL return to IDLE on that edge; a new operation SHALL NOT be accepted on the same edge (minimum issue interval N+2 cycles).
REQ-023 While in_ready=0, in_valid, a, b and sub SHALL be ignored.
REQ-024 flush=1 in BUSY or DONE SHALL force IDLE on the next edge, clear out_valid, and discard the partial result; flush in IDLE SHALL have no effect and SHALL block acceptance in that cycle.
REQ-025 If flush and out_ready are both 1 in DONE, flush SHALL take priority; the result SHALL NOT count as delivered.
REQ-026 When N=1 the block SHALL complete in one BUSY cycle with no other change in behaviour.

Reset
REQ-027 While rst_n=0, the block SHALL immediately, independent of clk, force state IDLE, in_ready=1, out_valid=0, result=0, cout=ovf=neg=0, zero=0, k=0 and running carry 0.
REQ-028 Reset asserted in BUSY or DONE SHALL abort the operation with no output produced; the first accept is permitted on the first rising edge after rst_n deasserts.

Verification (WIDTH=32, CHUNK=8)
REQ-029 Sub a=5, b=3 -> out_valid 4 cycles after accept; result=0x00000002, cout=0, ovf=0, zero=0, neg=0.
REQ-030 Sub a=3, b=5 -> result=0xFFFFFFFE, cout=1, neg=1, ovf=0; sub a=0x80000000, b=1 -> result=0x7FFFFFFF, ovf=1.
REQ-031 Add a=0xFFFFFFFF, b=1 -> result=0, cout=1, zero=1; add a=0x7FFFFFFF, b=1 -> result=0x80000000, ovf=1, neg=1, cout=0.
REQ-032 Hold out_ready=0 for 10 cycles in DONE while driving in_valid with new operands -> outputs unchanged and in_ready=0 throughout; after out_ready=1 the next operation is accepted one cycle later.
REQ-033 Assert rst_n=0 mid-BUSY (k=2) -> out_valid=0 and result=0 immediately; flush in BUSY -> IDLE next edge with no out_valid pulse.
REQ-034 Randomised add/sub against a reference model with WIDTH=16, CHUNK=4 and with WIDTH=8, CHUNK=8 -> result and all flags match for 10k operations with random backpressure.
